uart_fifo_bridge: RTL and testbench

//  Buffers the byte traffic between the pipeline's memory-mapped UART path and
//  the UART transmitter/receiver. The TX FIFO absorbs bursts of SB stores to
//  the UART data register. The RX FIFO holds received bytes until LB/LW polling

---
 rtl/uart_fifo_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_bridge_fifo
//  Purpose  : Single-clock show-ahead FIFO used for both directions of the
//             UART bridge. The head entry is read combinationally from the
//             storage array. A push is accepted only when the registered
//             occupancy is below depth. A pop is accepted only when the
//             registered occupancy is non-zero.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             push_i/push_data_i - write request and data
//             pop_i              - read request (advance head)
//             head_o             - current head entry (valid when !empty_o)
//             count_o            - occupancy, 0..2^DEPTH_LOG2
//             full_o / empty_o   - decoded from the registered count
//             push_ok_o          - push accepted this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  push_ok_o
);
    localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_CNT_MAX = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Full/empty come from the registered count so that a pop in the same
    // cycle never frees a slot for a push (and vice versa).
    assign full_o    = (count_q == c_CNT_MAX);
    assign empty_o   = (count_q == '0);
    assign w_push_ok = push_i && !full_o;
    assign w_pop_ok  = pop_i && !empty_o;
    assign push_ok_o = w_push_ok;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a write landing in the reset cycle is suppressed
    // so an aborted transfer leaves no trace beyond stale array contents.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// ============================================================================
//  Module   : uart_fifo_bridge
//  Purpose  : Decouples the CPU's memory-mapped UART accesses from the UART
//             transmitter/receiver with one FIFO per direction. The pipeline
//             never stalls: stores to a full TX FIFO are dropped and flagged
//             by a sticky overflow bit; loads from an empty RX FIFO are
//             ignored.
//  Ports    : CLK, reset                   - clock, sync active-high reset
//             tx_we, tx_byte               - CPU store into TX FIFO
//             tx_full, tx_count, tx_overflow - TX status for read mux
//             rx_re                        - CPU load pops RX FIFO
//             rx_byte, rx_valid, rx_count  - RX head and status
//             DataIn/DataInValid/DataInReady    - to UART transmitter
//             DataOut/DataOutValid/DataOutReady - from UART receiver
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  reset,
    // CPU side, TX direction
    input  logic                  tx_we,
    input  logic [7:0]            tx_byte,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  tx_overflow,
    // CPU side, RX direction
    input  logic                  rx_re,
    output logic [7:0]            rx_byte,
    output logic                  rx_valid,
    output logic [DEPTH_LOG2:0]   rx_count,
    // UART transmitter
    output logic [7:0]            DataIn,
    output logic                  DataInValid,
    input  logic                  DataInReady,
    // UART receiver
    input  logic [7:0]            DataOut,
    input  logic                  DataOutValid,
    output logic                  DataOutReady
);
    logic tx_empty;
    logic tx_push_ok;
    logic rx_full;
    logic rx_empty;
    logic rx_push_ok;
    logic tx_overflow_q, tx_overflow_d;

    uart_fifo_bridge_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_tx_fifo (
        .clk         (CLK),
        .rst         (reset),
        .push_i      (tx_we),
        .push_data_i (tx_byte),
        .pop_i       (DataInReady),
        .head_o      (DataIn),
        .count_o     (tx_count),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .push_ok_o   (tx_push_ok)
    );

    uart_fifo_bridge_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_rx_fifo (
        .clk         (CLK),
        .rst         (reset),
        .push_i      (DataOutValid),
        .push_data_i (DataOut),
        .pop_i       (rx_re),
        .head_o      (rx_byte),
        .count_o     (rx_count),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .push_ok_o   (rx_push_ok)
    );

    assign DataInValid  = !tx_empty;
    assign rx_valid     = !rx_empty;
    assign DataOutReady = !rx_full;

    // A store seen while full is lost; remember that until reset.
    always_comb begin
        tx_overflow_d = tx_overflow_q;
        if (tx_we && !tx_push_ok) begin
            tx_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            tx_overflow_q <= 1'b0;
        end else begin
            tx_overflow_q <= tx_overflow_d;
        end
    end

    assign tx_overflow = tx_overflow_q;

    // rx_push_ok mirrors DataOutValid && DataOutReady; exposed by the FIFO
    // for symmetry and intentionally unused at this level.
    logic unused_rx_push_ok;
    assign unused_rx_push_ok = rx_push_ok;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo_bridge
//  Purpose  : Directed self-checking bench for uart_fifo_bridge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_bridge;
    logic       CLK = 1'b0;
    logic       reset;
    logic       tx_we;
    logic [7:0] tx_byte;
    logic       tx_full;
    logic [3:0] tx_count;
    logic       tx_overflow;
    logic       rx_re;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;

    int total = 0;
    int bad   = 0;

    uart_fifo_bridge #(.DEPTH_LOG2(3)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .tx_we        (tx_we),
        .tx_byte      (tx_byte),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .tx_overflow  (tx_overflow),
        .rx_re        (rx_re),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_count     (rx_count),
        .DataIn       (DataIn),
        .DataInValid  (DataInValid),
        .DataInReady  (DataInReady),
        .DataOut      (DataOut),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        tx_we = 0; tx_byte = 0; rx_re = 0; DataInReady = 0;
        DataOut = 0; DataOutValid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL reset_tx_full got=%0b exp=0", tx_full); end
        total++; if (tx_count !== 4'd0) begin bad++; $display("FAIL reset_tx_count got=%0d exp=0", tx_count); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", tx_overflow); end
        total++; if (DataInValid !== 1'b0) begin bad++; $display("FAIL reset_DataInValid got=%0b exp=0", DataInValid); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
        total++; if (DataOutReady !== 1'b1) begin bad++; $display("FAIL reset_DataOutReady got=%0b exp=1", DataOutReady); end
    endtask

    task automatic test_tx_basic();
        logic [7:0] exp_b;
        tx_we = 1;
        for (int i = 0; i < 3; i++) begin
            tx_byte = 8'h41 + 8'(i);
            step();
        end
        tx_we = 0;
        total++; if (tx_count !== 4'd3) begin bad++; $display("FAIL tx_basic_count got=%0d exp=3", tx_count); end
        total++; if (DataInValid !== 1'b1) begin bad++; $display("FAIL tx_basic_valid got=%0b exp=1", DataInValid); end
        total++; if (DataIn !== 8'h41) begin bad++; $display("FAIL tx_basic_head got=%02h exp=41", DataIn); end
        // Holding Ready low must not move the head.
        step();
        total++; if (DataIn !== 8'h41) begin bad++; $display("FAIL tx_basic_stall got=%02h exp=41", DataIn); end
        DataInReady = 1;
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            total++; if (DataIn !== exp_b || DataInValid !== 1'b1) begin
                bad++; $display("FAIL tx_basic_order%0d got=%02h/%0b exp=%02h/1", i, DataIn, DataInValid, exp_b);
            end
            step();
        end
        DataInReady = 0;
        total++; if (DataInValid !== 1'b0) begin bad++; $display("FAIL tx_basic_drained got=%0b exp=0", DataInValid); end
    endtask

    task automatic test_tx_overflow();
        tx_we = 1;
        for (int i = 0; i < 8; i++) begin
            tx_byte = 8'(i);
            step();
        end
        total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b exp=1", tx_full); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", tx_overflow); end
        tx_byte = 8'h08;
        step();
        tx_we = 0;
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", tx_overflow); end
        total++; if (tx_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", tx_count); end
    endtask

    task automatic test_full_push_pop();
        // FIFO holds 0..7 and is full: simultaneous push and pop -> pop only.
        tx_we = 1; tx_byte = 8'hAA; DataInReady = 1;
        step();
        tx_we = 0;
        total++; if (tx_count !== 4'd7) begin bad++; $display("FAIL fullpp_count got=%0d exp=7", tx_count); end
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL fullpp_overflow got=%0b exp=1", tx_overflow); end
        for (int i = 1; i < 8; i++) begin
            total++; if (DataIn !== 8'(i)) begin bad++; $display("FAIL fullpp_order%0d got=%02h exp=%02h", i, DataIn, 8'(i)); end
            step();
        end
        DataInReady = 0;
        total++; if (DataInValid !== 1'b0 || tx_count !== 4'd0) begin
            bad++; $display("FAIL fullpp_drained got=%0b/%0d exp=0/0", DataInValid, tx_count);
        end
    endtask

    task automatic test_reset_mid();
        // tx_overflow is still set from the overflow test.
        tx_we = 1; DataOutValid = 1;
        for (int i = 0; i < 5; i++) begin
            tx_we = (i < 4);
            tx_byte = 8'hC0 + 8'(i);
            DataOut = 8'hD0 + 8'(i);
            step();
        end
        total++; if (tx_count !== 4'd4 || rx_count !== 4'd5) begin
            bad++; $display("FAIL rstmid_pre got=%0d/%0d exp=4/5", tx_count, rx_count);
        end
        // Handshakes in the reset cycle are discarded.
        reset = 1; tx_we = 1; DataInReady = 1; rx_re = 1; DataOutValid = 1;
        step();
        reset = 0;
        idle_inputs();
        total++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin
            bad++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", tx_count, rx_count);
        end
        total++; if (DataInValid !== 1'b0 || DataOutReady !== 1'b1) begin
            bad++; $display("FAIL rstmid_flags got=%0b/%0b exp=0/1", DataInValid, DataOutReady);
        end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got=%0b exp=0", tx_overflow); end
    endtask

    task automatic test_rx();
        int         idx;
        logic       rdy;
        logic [7:0] exp_b;
        idx = 0;
        DataOutValid = 1;
        for (int c = 0; c < 14; c++) begin
            DataOut = 8'h10 + 8'(idx);
            rdy = DataOutReady;
            step();
            if (rdy) idx++;
        end
        DataOutValid = 0;
        total++; if (idx !== 8) begin bad++; $display("FAIL rx_accepted got=%0d exp=8", idx); end
        total++; if (DataOutReady !== 1'b0 || rx_count !== 4'd8) begin
            bad++; $display("FAIL rx_full got=%0b/%0d exp=0/8", DataOutReady, rx_count);
        end
        for (int k = 0; k < 8; k++) begin
            exp_b = 8'h10 + 8'(k);
            total++; if (rx_byte !== exp_b || rx_valid !== 1'b1) begin
                bad++; $display("FAIL rx_order%0d got=%02h/%0b exp=%02h/1", k, rx_byte, rx_valid, exp_b);
            end
            rx_re = 1;
            step();
        end
        total++; if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin
            bad++; $display("FAIL rx_drained got=%0b/%0d exp=0/0", rx_valid, rx_count);
        end
        step();
        rx_re = 0;
        total++; if (rx_count !== 4'd0 || DataOutReady !== 1'b1) begin
            bad++; $display("FAIL rx_empty_pop got=%0d/%0b exp=0/1", rx_count, DataOutReady);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_b;
        tx_we = 1; tx_byte = 8'h80;
        step();
        DataInReady = 1;
        for (int i = 0; i < 20; i++) begin
            exp_b = 8'h80 + 8'(i);
            tx_byte = 8'h81 + 8'(i);
            total++; if (DataIn !== exp_b) begin bad++; $display("FAIL wrap_data%0d got=%02h exp=%02h", i, DataIn, exp_b); end
            step();
            total++; if (tx_count !== 4'd1) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=1", i, tx_count); end
        end
        tx_we = 0;
        total++; if (DataIn !== 8'h94) begin bad++; $display("FAIL wrap_last got=%02h exp=94", DataIn); end
        step();
        DataInReady = 0;
        total++; if (DataInValid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%0b exp=0", DataInValid); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_rx();
        test_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
